// File: rtl/dom_rand_pkg.sv
// Shared constants, state encoding and sizing helpers for the DOM
// fresh-randomness generator.
package dom_rand_pkg;

  // Feedback taps of x^32 + x^22 + x^2 + x + 1 in right-shift Galois form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // The all-zero LFSR state is a fixed point, so a zero seed is replaced
  localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    WARM,
    RUN
  } randState_e;

  // Total fresh bits needed per cycle: Z plus B for every multiplier
  function automatic int randBits(input int shares, input int nMult);
    return nMult * (shares * (shares - 1) + 2 * shares);
  endfunction

  // Number of 32-bit lanes needed to cover all fresh bits
  function automatic int laneCount(input int shares, input int nMult);
    return (randBits(shares, nMult) + 31) / 32;
  endfunction

endpackage

// File: rtl/lfsr32_step32.sv
// Combinational 32-step advance of one Galois LFSR lane, so every cycle
// yields a completely new 32-bit word with no shifted-over bits.
module lfsr32_step32
  import dom_rand_pkg::*;
(
  input  logic [31:0] i_state,
  output logic [31:0] o_state
);

  logic [31:0] w_acc;

  // Unrolled chain of 32 single Galois right-shift steps
  always_comb begin
    w_acc = i_state;
    for (int k = 0; k < 32; k++) begin
      if (w_acc[0]) begin
        w_acc = (w_acc >> 1) ^ LFSR_POLY;
      end else begin
        w_acc = w_acc >> 1;
      end
    end
  end

  assign o_state = w_acc;

endmodule

// File: rtl/dom_rand_gen.sv
// Fresh-randomness source for a DOM masked S-box: drives the remask (Z)
// and blinding (B) inputs of all shared multipliers from LFSR lanes that
// are seeded by handshake and warmed up before randomness is flagged valid.
module dom_rand_gen
  import dom_rand_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int N_MULT = 3,
  parameter int WARMUP = 4
) (
  input  logic                                ClkxCI,
  input  logic                                RstxBI,
  input  logic [31:0]                         SeedxDI,
  input  logic                                SeedValidxSI,
  output logic                                SeedReadyxSO,
  input  logic                                EnxSI,
  output logic                                RandValidxSO,
  output logic [N_MULT*SHARES*(SHARES-1)-1:0] ZxDO,
  output logic [N_MULT*2*SHARES-1:0]          BxDO
);

  localparam int ZW        = N_MULT * SHARES * (SHARES - 1);
  localparam int RAND_BITS = randBits(SHARES, N_MULT);
  localparam int LANES     = laneCount(SHARES, N_MULT);
  localparam int CNT_W     = (LANES > 1) ? $clog2(LANES) : 1;

  randState_e                  r_state;
  randState_e                  w_nextState;
  logic [LANES-1:0][31:0]      r_lanes;
  logic [LANES-1:0][31:0]      w_lanesAdv;
  logic [CNT_W-1:0]            r_seedCnt;
  logic [7:0]                  r_warmCnt;
  logic [31:0]                 w_seedFixed;
  logic [RAND_BITS-1:0]        w_pool;

  logic w_seedReady;
  logic w_randValid;
  logic w_load;
  logic w_step;
  logic w_seedCntClr;
  logic w_seedCntInc;
  logic w_warmLoad;

  // One combinational 32-step advance per lane
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lfsr32_step32 u_step (
      .i_state (r_lanes[g]),
      .o_state (w_lanesAdv[g])
    );
  end

  assign w_seedFixed = (SeedxDI == 32'h0) ? ZERO_SEED_SUB : SeedxDI;

  // Outputs come straight from lane registers; lanes beyond RAND_BITS are dropped
  assign w_pool = RAND_BITS'(r_lanes);
  assign ZxDO   = w_pool[ZW-1:0];
  assign BxDO   = w_pool[RAND_BITS-1:ZW];

  // Ready is forced low while reset is held so no seed is offered during reset
  assign SeedReadyxSO = w_seedReady & RstxBI;
  assign RandValidxSO = w_randValid;

  // State register
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus the load/step/counter controls for the datapath
  always_comb begin
    w_nextState  = r_state;
    w_seedReady  = 1'b0;
    w_randValid  = 1'b0;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_seedCntClr = 1'b0;
    w_seedCntInc = 1'b0;
    w_warmLoad   = 1'b0;
    case (r_state)
      IDLE, SEED: begin
        w_seedReady = 1'b1;
        if (SeedValidxSI) begin
          w_load = 1'b1;
          if (r_seedCnt == CNT_W'(LANES - 1)) begin
            w_nextState  = WARM;
            w_warmLoad   = 1'b1;
            w_seedCntClr = 1'b1;
          end else begin
            w_nextState  = SEED;
            w_seedCntInc = 1'b1;
          end
        end
      end
      WARM: begin
        w_step = 1'b1;
        if (r_warmCnt == 8'd0) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_seedReady = 1'b1;
        w_randValid = 1'b1;
        if (SeedValidxSI) begin
          w_load = 1'b1;
          if (LANES == 1) begin
            w_nextState  = WARM;
            w_warmLoad   = 1'b1;
            w_seedCntClr = 1'b1;
          end else begin
            w_nextState  = SEED;
            w_seedCntInc = 1'b1;
          end
        end else if (EnxSI) begin
          w_step = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Lane registers: a seed load takes priority over stepping, otherwise hold
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_lanes <= '0;
    end else if (w_load) begin
      for (int l = 0; l < LANES; l++) begin
        if (r_seedCnt == CNT_W'(l)) begin
          r_lanes[l] <= w_seedFixed;
        end
      end
    end else if (w_step) begin
      r_lanes <= w_lanesAdv;
    end
  end

  // Index of the lane the next seed handshake loads
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_seedCnt <= '0;
    end else if (w_seedCntClr) begin
      r_seedCnt <= '0;
    end else if (w_seedCntInc) begin
      r_seedCnt <= r_seedCnt + CNT_W'(1);
    end
  end

  // Warm-up countdown; reaching zero in WARM hands over to RUN
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_warmCnt <= 8'd0;
    end else if (w_warmLoad) begin
      r_warmCnt <= 8'(WARMUP - 1);
    end else if (r_state == WARM && r_warmCnt != 8'd0) begin
      r_warmCnt <= r_warmCnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_dom_rand_gen.sv
// Directed bench for dom_rand_gen using three configurations: a single
// lane (SHARES=2,N_MULT=1), a single lane serving three multipliers, and
// a two-lane build (SHARES=3,N_MULT=3).
module tb_dom_rand_gen;

  logic        ClkxCI = 1'b0;
  logic        RstxBI;

  logic [31:0] seedA, seedB, seedC;
  logic        svA, svB, svC;
  logic        enA, enB, enC;
  logic        rdyA, rdyB, rdyC;
  logic        rvA, rvB, rvC;
  logic [1:0]  zA;
  logic [3:0]  bA;
  logic [5:0]  zB;
  logic [11:0] bB;
  logic [17:0] zC;
  logic [17:0] bC;

  logic [31:0] mA, mB, mC0, mC1;
  logic [63:0] poolC;

  int errCount   = 0;
  int checkCount = 0;

  always #5 ClkxCI = ~ClkxCI;

  dom_rand_gen #(.SHARES(2), .N_MULT(1), .WARMUP(4)) dutA (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .SeedxDI(seedA), .SeedValidxSI(svA),
    .SeedReadyxSO(rdyA), .EnxSI(enA), .RandValidxSO(rvA), .ZxDO(zA), .BxDO(bA)
  );

  dom_rand_gen #(.SHARES(2), .N_MULT(3), .WARMUP(4)) dutB (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .SeedxDI(seedB), .SeedValidxSI(svB),
    .SeedReadyxSO(rdyB), .EnxSI(enB), .RandValidxSO(rvB), .ZxDO(zB), .BxDO(bB)
  );

  dom_rand_gen #(.SHARES(3), .N_MULT(3), .WARMUP(4)) dutC (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .SeedxDI(seedC), .SeedValidxSI(svC),
    .SeedReadyxSO(rdyC), .EnxSI(enC), .RandValidxSO(rvC), .ZxDO(zC), .BxDO(bC)
  );

  // Reference lane advance: 32 single Galois right-shift steps
  function automatic logic [31:0] adv32(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int k = 0; k < 32; k++) begin
      if (t[0]) t = (t >> 1) ^ 32'h8020_0003;
      else      t = t >> 1;
    end
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Wait for the next rising edge, then settle before sampling or driving
  task automatic tick();
    @(posedge ClkxCI);
    #1;
  endtask

  task automatic checkA(input string tag);
    checkOutput({tag, ".z"}, 64'(zA), 64'(mA[1:0]));
    checkOutput({tag, ".b"}, 64'(bA), 64'(mA[5:2]));
  endtask

  task automatic checkB(input string tag);
    checkOutput({tag, ".z"}, 64'(zB), 64'(mB[5:0]));
    checkOutput({tag, ".b"}, 64'(bB), 64'(mB[17:6]));
  endtask

  task automatic checkC(input string tag);
    poolC = {mC1, mC0};
    checkOutput({tag, ".z"}, 64'(zC), 64'(poolC[17:0]));
    checkOutput({tag, ".b"}, 64'(bC), 64'(poolC[35:18]));
  endtask

  initial begin
    RstxBI = 1'b0;
    seedA = '0; seedB = '0; seedC = '0;
    svA = 1'b0; svB = 1'b0; svC = 1'b0;
    enA = 1'b0; enB = 1'b0; enC = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    checkOutput("rst.readyA", 64'(rdyA), 64'd0);
    checkOutput("rst.validA", 64'(rvA), 64'd0);
    checkOutput("rst.zA", 64'(zA), 64'd0);
    checkOutput("rst.bA", 64'(bA), 64'd0);
    checkOutput("rst.zC", 64'(zC), 64'd0);
    RstxBI = 1'b1;
    #1;
    checkOutput("rel.readyA", 64'(rdyA), 64'd1);
    checkOutput("rel.validA", 64'(rvA), 64'd0);

    // ---------------- A: zero seed, warm-up timing ----------------
    seedA = 32'h0000_0000;
    svA   = 1'b1;
    tick();
    mA = 32'h0000_0001;
    checkA("A.seed");
    checkOutput("A.seed.ready", 64'(rdyA), 64'd0);
    checkOutput("A.seed.valid", 64'(rvA), 64'd0);
    seedA = 32'hFFFF_FFFF;
    for (int i = 1; i <= 4; i++) begin
      tick();
      mA = adv32(mA);
      checkOutput($sformatf("A.warm%0d.valid", i), 64'(rvA), 64'(i == 4));
      checkOutput($sformatf("A.warm%0d.ready", i), 64'(rdyA), 64'(i == 4));
      checkA($sformatf("A.warm%0d", i));
    end
    svA = 1'b0;
    enA = 1'b0;
    tick();
    checkA("A.hold");
    enA = 1'b1;
    tick();
    mA = adv32(mA);
    checkA("A.en");

    // ---------------- B: three multipliers, enable 1,0,1 ----------------
    seedB = 32'hACE1_2345;
    svB   = 1'b1;
    tick();
    mB  = 32'hACE1_2345;
    svB = 1'b0;
    checkB("B.seed");
    for (int i = 1; i <= 4; i++) begin
      tick();
      mB = adv32(mB);
      checkOutput($sformatf("B.warm%0d.valid", i), 64'(rvB), 64'(i == 4));
    end
    checkB("B.run");
    for (int i = 0; i < 3; i++) begin
      enB = (i != 1);
      tick();
      if (enB) mB = adv32(mB);
      checkB($sformatf("B.en%0d", i));
      checkOutput($sformatf("B.en%0d.z.m2", i), 64'(zB[4 +: 2]), 64'(mB[4 +: 2]));
      checkOutput($sformatf("B.en%0d.b.m2", i), 64'(bB[8 +: 4]), 64'(mB[14 +: 4]));
    end
    enB = 1'b0;

    // ---------------- C: two lanes, reseed with enable ----------------
    seedC = 32'h1234_5678;
    svC   = 1'b1;
    tick();
    mC0 = 32'h1234_5678;
    mC1 = 32'h0;
    checkC("C.seed0");
    checkOutput("C.seed0.ready", 64'(rdyC), 64'd1);
    checkOutput("C.seed0.valid", 64'(rvC), 64'd0);
    seedC = 32'hDEAD_BEEF;
    tick();
    mC1 = 32'hDEAD_BEEF;
    svC = 1'b0;
    checkC("C.seed1");
    checkOutput("C.seed1.ready", 64'(rdyC), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      mC0 = adv32(mC0);
      mC1 = adv32(mC1);
      checkOutput($sformatf("C.warm%0d.valid", i), 64'(rvC), 64'(i == 4));
    end
    checkC("C.run");
    enC = 1'b1;
    tick();
    mC0 = adv32(mC0);
    mC1 = adv32(mC1);
    checkC("C.en");
    seedC = 32'h0000_0000;
    svC   = 1'b1;
    tick();
    mC0 = 32'h0000_0001;
    checkC("C.reseed");
    checkOutput("C.reseed.valid", 64'(rvC), 64'd0);
    checkOutput("C.reseed.ready", 64'(rdyC), 64'd1);
    seedC = 32'h55AA_55AA;
    enC   = 1'b0;
    tick();
    mC1 = 32'h55AA_55AA;
    svC = 1'b0;
    checkC("C.reseed1");
    for (int i = 1; i <= 4; i++) begin
      tick();
      mC0 = adv32(mC0);
      mC1 = adv32(mC1);
      checkOutput($sformatf("C.rewarm%0d.valid", i), 64'(rvC), 64'(i == 4));
    end
    checkC("C.rerun");

    // ---------------- A: reseed in RUN, then reset during WARM ----------------
    seedA = 32'h0BAD_F00D;
    svA   = 1'b1;
    enA   = 1'b1;
    tick();
    mA = 32'h0BAD_F00D;
    checkA("A.reseed");
    checkOutput("A.reseed.valid", 64'(rvA), 64'd0);
    checkOutput("A.reseed.ready", 64'(rdyA), 64'd0);
    seedA = 32'hFFFF_FFFF;
    enA   = 1'b0;
    tick();
    mA = adv32(mA);
    checkA("A.rewarm");
    #2;
    RstxBI = 1'b0;
    #1;
    checkOutput("A.midrst.ready", 64'(rdyA), 64'd0);
    checkOutput("A.midrst.valid", 64'(rvA), 64'd0);
    checkOutput("A.midrst.z", 64'(zA), 64'd0);
    checkOutput("A.midrst.b", 64'(bA), 64'd0);
    tick();
    RstxBI = 1'b1;
    svA    = 1'b0;
    #1;
    checkOutput("A.postrst.ready", 64'(rdyA), 64'd1);
    checkOutput("A.postrst.valid", 64'(rvA), 64'd0);
    tick();
    checkOutput("A.postrst.z", 64'(zA), 64'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
